m_filter: RTL and testbench

Parametrised packet filter for the ingress word stream. It tracks each packet from SOP to EOP and compares a configurable multi-byte packet-type field at any byte offset, even across word boundaries. It also searches all valid payload bytes for up to N_SYM symbol bytes. Every accepted word is passed through, and the EOP word carries the computed `buffer` decision. Per-stream statistics counters are also maintained. It is the generalised successor of the single-word-width matcher and sits between ingress framing and the buffering stage.

---
 rtl/m_filter.sv | 180 ++++++++++++++++++
 tb/tb_m_filter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/m_filter.sv
// rtl/m_filter.sv - packet filter: type-field and symbol matcher with per-stream counters
module m_filter #(
    parameter int W_BYTES    = 8,
    parameter int TYPE_BYTES = 2,
    parameter int OFF_W      = 8,
    parameter int N_SYM      = 2,
    parameter int LEN_W      = $clog2(W_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld_w,
    input  logic                    in_sop_w,
    input  logic                    in_eop_w,
    input  logic [LEN_W-1:0]        in_len_w,
    input  logic [8*W_BYTES-1:0]    in_data_w,
    input  logic [OFF_W-1:0]        type_off_w,
    input  logic [8*TYPE_BYTES-1:0] type_w,
    input  logic [8*N_SYM-1:0]      sym_w,
    input  logic [N_SYM-1:0]        sym_en_w,
    output logic                    out_vld_r,
    output logic                    out_sop_r,
    output logic                    out_eop_r,
    output logic [LEN_W-1:0]        out_len_r,
    output logic [8*W_BYTES-1:0]    out_data_r,
    output logic                    out_buffer_r,
    output logic [31:0]             pkt_cnt_r,
    output logic [31:0]             buf_cnt_r,
    output logic [31:0]             err_cnt_r
);
    localparam int LANE_W = $clog2(W_BYTES);
    localparam int IDX_W  = OFF_W - LANE_W + 1;
    // Packet byte position of a type byte: offset plus up to 3, with headroom.
    localparam int POS_W  = OFF_W + 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;

    logic                    s0_vld_q, s0_sop_q, s0_eop_q;
    logic [LEN_W-1:0]        s0_len_q;
    logic [8*W_BYTES-1:0]    s0_data_q;

    logic [OFF_W-1:0]        off_q;
    logic [8*TYPE_BYTES-1:0] type_q;
    logic [8*N_SYM-1:0]      sym_q;
    logic [N_SYM-1:0]        sym_en_q;

    logic [0:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, cur_idx;
    logic [TYPE_BYTES-1:0]   type_hit_q, type_hit_d, type_now, type_acc;
    logic [N_SYM-1:0]        sym_hit_q, sym_hit_d, sym_now, sym_acc;
    logic [POS_W-1:0]        pos_c;
    logic                    buf_c, emit_c, err_c;

    logic                    s1_vld_q, s1_sop_q, s1_eop_q, s1_buf_q, s1_err_q;
    logic [LEN_W-1:0]        s1_len_q;
    logic [8*W_BYTES-1:0]    s1_data_q;

    // Stage 0: register the incoming word; payload only moves on valid cycles.
    always_ff @(posedge clk) begin
        if (rst) s0_vld_q <= 1'b0;
        else     s0_vld_q <= in_vld_w;
        if (in_vld_w) begin
            s0_sop_q  <= in_sop_w;
            s0_eop_q  <= in_eop_w;
            s0_len_q  <= in_len_w;
            s0_data_q <= in_data_w;
        end
    end

    // Match operands are sampled with the SOP word and held for the packet.
    always_ff @(posedge clk) begin
        if (in_vld_w && in_sop_w) begin
            off_q    <= type_off_w;
            type_q   <= type_w;
            sym_q    <= sym_w;
            sym_en_q <= sym_en_w;
        end
    end

    // Per-word comparisons, accumulator update and packet-tracking FSM.
    always_comb begin
        // A SOP always starts at word 0 with fresh accumulators, even on abort.
        cur_idx  = s0_sop_q ? '0 : idx_q;
        pos_c    = '0;
        type_now = '0;
        for (int k = 0; k < TYPE_BYTES; k++) begin
            pos_c = POS_W'(off_q) + POS_W'(k);
            if (((pos_c >> LANE_W) == POS_W'(cur_idx)) &&
                (LEN_W'(pos_c[LANE_W-1:0]) < s0_len_q) &&
                (s0_data_q[{pos_c[LANE_W-1:0], 3'b000} +: 8] == type_q[8*k +: 8]))
                type_now[k] = 1'b1;
        end
        sym_now = '0;
        for (int j = 0; j < N_SYM; j++) begin
            for (int i = 0; i < W_BYTES; i++) begin
                if ((LEN_W'(i) < s0_len_q) && (s0_data_q[8*i +: 8] == sym_q[8*j +: 8]))
                    sym_now[j] = 1'b1;
            end
        end
        type_acc = (s0_sop_q ? '0 : type_hit_q) | type_now;
        sym_acc  = (s0_sop_q ? '0 : sym_hit_q) | sym_now;
        buf_c    = (&type_acc) & (&(sym_acc | ~sym_en_q));

        state_d    = state_q;
        idx_d      = idx_q;
        type_hit_d = type_hit_q;
        sym_hit_d  = sym_hit_q;
        emit_c     = 1'b0;
        err_c      = 1'b0;
        if (s0_vld_q) begin
            if (s0_sop_q) begin
                emit_c     = 1'b1;
                err_c      = (state_q == S_PKT);
                state_d    = s0_eop_q ? S_IDLE : S_PKT;
                idx_d      = IDX_W'(1);
                type_hit_d = type_acc;
                sym_hit_d  = sym_acc;
            end else if (state_q == S_IDLE) begin
                err_c = 1'b1;
            end else begin
                emit_c     = 1'b1;
                type_hit_d = type_acc;
                sym_hit_d  = sym_acc;
                if (s0_eop_q)          state_d = S_IDLE;
                else if (idx_q != '1)  idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    // Stage 1: FSM state, sticky hits and the decided word awaiting output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            type_hit_q <= '0;
            sym_hit_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            type_hit_q <= type_hit_d;
            sym_hit_q  <= sym_hit_d;
            s1_vld_q   <= emit_c;
            s1_err_q   <= err_c;
        end
        if (emit_c) begin
            s1_sop_q  <= s0_sop_q;
            s1_eop_q  <= s0_eop_q;
            s1_len_q  <= s0_len_q;
            s1_data_q <= s0_data_q;
            s1_buf_q  <= s0_eop_q & buf_c;
        end
    end

    // Stage 2: output word and saturating statistics, updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_r <= 1'b0;
            pkt_cnt_r <= '0;
            buf_cnt_r <= '0;
            err_cnt_r <= '0;
        end else begin
            out_vld_r <= s1_vld_q;
            if (s1_vld_q && s1_eop_q && (pkt_cnt_r != '1))
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            if (s1_vld_q && s1_eop_q && s1_buf_q && (buf_cnt_r != '1))
                buf_cnt_r <= buf_cnt_r + 32'd1;
            if (s1_err_q && (err_cnt_r != '1))
                err_cnt_r <= err_cnt_r + 32'd1;
        end
        if (s1_vld_q) begin
            out_sop_r    <= s1_sop_q;
            out_eop_r    <= s1_eop_q;
            out_len_r    <= s1_len_q;
            out_data_r   <= s1_data_q;
            out_buffer_r <= s1_buf_q;
        end
    end
endmodule

// File: tb/tb_m_filter.sv
// tb/tb_m_filter.sv - directed self-checking bench for m_filter
module tb_m_filter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld_w = 1'b0, in_sop_w = 1'b0, in_eop_w = 1'b0;
    logic [3:0]  in_len_w = '0;
    logic [63:0] in_data_w = '0;
    logic [7:0]  type_off_w = '0;
    logic [15:0] type_w = '0;
    logic [15:0] sym_w = '0;
    logic [1:0]  sym_en_w = '0;
    logic        out_vld_r, out_sop_r, out_eop_r, out_buffer_r;
    logic [3:0]  out_len_r;
    logic [63:0] out_data_r;
    logic [31:0] pkt_cnt_r, buf_cnt_r, err_cnt_r;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic        sop;
        logic        eop;
        int          len;
        logic        buffer;
        logic [63:0] data;
    } ow_t;

    ow_t exp_q[$];
    ow_t got_q[$];

    m_filter dut (
        .clk(clk), .rst(rst),
        .in_vld_w(in_vld_w), .in_sop_w(in_sop_w), .in_eop_w(in_eop_w),
        .in_len_w(in_len_w), .in_data_w(in_data_w),
        .type_off_w(type_off_w), .type_w(type_w), .sym_w(sym_w), .sym_en_w(sym_en_w),
        .out_vld_r(out_vld_r), .out_sop_r(out_sop_r), .out_eop_r(out_eop_r),
        .out_len_r(out_len_r), .out_data_r(out_data_r), .out_buffer_r(out_buffer_r),
        .pkt_cnt_r(pkt_cnt_r), .buf_cnt_r(buf_cnt_r), .err_cnt_r(err_cnt_r)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp accepted and emitted words.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (out_vld_r)
            got_q.push_back('{cyc, out_sop_r, out_eop_r, int'(out_len_r), out_buffer_r, out_data_r});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sop, input logic eop, input int len, input logic [63:0] data,
                        input logic emit, input logic exp_buf);
        @(negedge clk);
        in_vld_w  = 1'b1;
        in_sop_w  = sop;
        in_eop_w  = eop;
        in_len_w  = 4'(len);
        in_data_w = data;
        @(posedge clk);
        #1;
        in_vld_w = 1'b0;
        if (emit) exp_q.push_back('{cyc + 2, sop, eop, len, exp_buf, data});
    endtask

    task automatic drain(input string tag, input int pkt, input int bufc, input int err);
        ow_t e, g;
        int  n;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({tag, ".nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk($sformatf("%s.w%0d.cyc", tag, n), 64'(g.cyc), 64'(e.cyc));
            chk($sformatf("%s.w%0d.sop", tag, n), 64'(g.sop), 64'(e.sop));
            chk($sformatf("%s.w%0d.eop", tag, n), 64'(g.eop), 64'(e.eop));
            chk($sformatf("%s.w%0d.len", tag, n), 64'(g.len), 64'(e.len));
            chk($sformatf("%s.w%0d.buffer", tag, n), 64'(g.buffer), 64'(e.buffer));
            chk($sformatf("%s.w%0d.data", tag, n), g.data, e.data);
            n++;
        end
        exp_q.delete();
        got_q.delete();
        chk({tag, ".pkt_cnt"}, 64'(pkt_cnt_r), 64'(pkt));
        chk({tag, ".buf_cnt"}, 64'(buf_cnt_r), 64'(bufc));
        chk({tag, ".err_cnt"}, 64'(err_cnt_r), 64'(err));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.out_vld", 64'(out_vld_r), 64'd0);
        chk("reset.pkt_cnt", 64'(pkt_cnt_r), 64'd0);
        chk("reset.buf_cnt", 64'(buf_cnt_r), 64'd0);
        chk("reset.err_cnt", 64'(err_cnt_r), 64'd0);

        // Single-word packet, type at bytes 2..3.
        type_off_w = 8'd2; type_w = 16'hBBAA; sym_w = 16'h6655; sym_en_w = 2'b00;
        send(1, 1, 8, 64'h0000_0000_BBAA_0000, 1, 1);
        drain("t1", 1, 1, 0);

        // Type field straddling a word boundary; mid-packet operand change ignored.
        type_off_w = 8'd7; type_w = 16'hBBAA;
        send(1, 0, 8, 64'hAA00_0000_0000_0000, 1, 0);
        type_w = 16'h1234;
        send(0, 1, 8, 64'h0000_0000_0000_00BB, 1, 1);
        drain("t2a", 2, 2, 0);
        type_w = 16'hBBAA;
        send(1, 0, 8, 64'hAA00_0000_0000_0000, 1, 0);
        send(0, 1, 8, 64'h0000_0000_0000_00BC, 1, 0);
        drain("t2b", 3, 2, 0);

        // Type field beyond EOP, then reached in word 2 with len boundary.
        type_off_w = 8'd20;
        send(1, 0, 8, 64'h0000_BBAA_0000_0000, 1, 0);
        send(0, 1, 4, 64'h0000_0000_BBAA_0000, 1, 0);
        drain("t3a", 4, 2, 0);
        send(1, 0, 8, 64'h0000_BBAA_0000_0000, 1, 0);
        send(0, 0, 8, 64'h0000_BBAA_0000_0000, 1, 0);
        send(0, 1, 6, 64'h0000_BBAA_0000_0000, 1, 1);
        drain("t3b", 5, 3, 0);
        send(1, 0, 8, 64'h0000_BBAA_0000_0000, 1, 0);
        send(0, 0, 8, 64'h0000_BBAA_0000_0000, 1, 0);
        send(0, 1, 5, 64'h0000_BBAA_0000_0000, 1, 0);
        drain("t3c", 6, 3, 0);

        // Symbol search with valid-lane boundary and enable mask.
        type_off_w = 8'd0; type_w = 16'h2211; sym_en_w = 2'b01;
        send(1, 0, 8, 64'h0000_0000_0000_2211, 1, 0);
        send(0, 1, 3, 64'h0000_0000_5500_0000, 1, 0);
        drain("t4a", 7, 3, 0);
        send(1, 0, 8, 64'h0000_0000_0000_2211, 1, 0);
        send(0, 1, 4, 64'h0000_0000_5500_0000, 1, 1);
        drain("t4b", 8, 4, 0);
        sym_en_w = 2'b11;
        send(1, 0, 8, 64'h0000_0000_0000_2211, 1, 0);
        send(0, 1, 4, 64'h0000_0000_5500_0000, 1, 0);
        drain("t4c", 9, 4, 0);
        send(1, 0, 8, 64'h6600_0000_0000_2211, 1, 0);
        send(0, 1, 4, 64'h0000_0000_5500_0000, 1, 1);
        drain("t4d", 10, 5, 0);

        // Protocol errors: stray word in IDLE, then abort by a new SOP.
        sym_en_w = 2'b00;
        send(0, 0, 8, 64'h0123_4567_89AB_CDEF, 0, 0);
        drain("t5a", 10, 5, 1);
        type_off_w = 8'd2; type_w = 16'hBBAA;
        send(1, 0, 8, 64'h0000_0000_BBAA_0000, 1, 0);
        type_off_w = 8'd0; type_w = 16'h2211;
        send(1, 0, 8, 64'h0000_0000_0000_0000, 1, 0);
        send(0, 1, 8, 64'h0000_0000_0000_0000, 1, 0);
        drain("t5b", 11, 5, 2);

        // Reset mid-packet, stray words after it, then a packet with bubbles.
        send(1, 0, 8, 64'h0000_0000_0000_2211, 0, 0);
        send(0, 0, 8, 64'h1111_1111_1111_1111, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6.rst.out_vld", 64'(out_vld_r), 64'd0);
        chk("t6.rst.pkt_cnt", 64'(pkt_cnt_r), 64'd0);
        chk("t6.rst.buf_cnt", 64'(buf_cnt_r), 64'd0);
        chk("t6.rst.err_cnt", 64'(err_cnt_r), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        send(0, 0, 8, 64'h2222_2222_2222_2222, 0, 0);
        send(0, 1, 8, 64'h3333_3333_3333_3333, 0, 0);
        drain("t6a", 0, 0, 2);
        send(1, 0, 8, 64'h0000_0000_0000_2211, 1, 0);
        repeat (2) @(posedge clk);
        send(0, 0, 8, 64'h0000_0000_0000_0000, 1, 0);
        repeat (3) @(posedge clk);
        send(0, 1, 2, 64'h0000_0000_0000_0077, 1, 1);
        drain("t6b", 1, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
